sap_control_seq: RTL and testbench
==================================

// Module: sap_control_seq
// PURPOSE
//  Microcoded control sequencer for the 8-bit CPU. Consumes ALUFlags' cf/zf and
//  the instruction register opcode, and drives the control word (su, eo_, fi_,
//  register load/enable lines) for ALUFlags, the A/B registers, PC, MAR, RAM and
//  the output register. It consists of a step counter plus a halt FSM. Each
//  instruction takes 3-5 cycles.
// PARAMETERS
//  OPW    4  opcode width (ir_op)
//  NSTEP  5  maximum micro-steps per instruction (T0..T4); step width = $clog2(NSTEP)
// PORTS
//  clk     in   1    system clock; all state on rising edge
//  rst     in   1    synchronous, active-high reset
//  ir_op   in   OPW  opcode field of instruction register (valid from T2)
//  cf      in   1    registered carry flag from ALUFlags
//  zf      in   1    registered zero flag from ALUFlags
//  hlt     out  1    halt (active-high)
//  mi_,ri_,ro_,io_,ii_,ai_,ao_,eo_,bi_,oi_,co_,j_,fi_  out 1 each, active-low
//                    MAR in, RAM in/out, IR out/in, A in/out, ALU out, B in,
//                    OUT in, PC out, PC jump, flags in
//  su      out  1    ALU subtract (active-high)
//  ce      out  1    PC count enable (active-high)
//  step    out  3    current micro-step (debug)
//  halted  out  1    halt state reached
// BEHAVIOUR
//  - Idle word: all *_ outputs =1; hlt, su, ce = 0. This is the output while rst=1
//    and during the reset cycle. Reset gives step=0 and halted=0.
//  - The control word is combinational from (step, ir_op, cf, zf, halted).
//    It is valid in the same cycle as step. The step register advances on clk.
//  - Fetch, every opcode: T0 co_,mi_; T1 ro_,ii_,ce.
//  - Execute (lines listed are asserted; the last listed step ends the instruction):
//    0000 NOP  : none (T2 idle, end)
//    0001 LDA  : T2 io_,mi_ ; T3 ro_,ai_
//    0010 ADD  : T2 io_,mi_ ; T3 ro_,bi_ ; T4 eo_,ai_,fi_
//    0011 SUB  : same as ADD, with su=1 in T3 and T4
//    0100 STA  : T2 io_,mi_ ; T3 ao_,ri_
//    0101 LDI  : T2 io_,ai_
//    0110 JMP  : T2 io_,j_
//    0111 JC   : T2 io_, plus j_ only if cf=1
//    1000 JZ   : T2 io_, plus j_ only if zf=1
//    1110 OUT  : T2 ao_,oi_
//    1111 HLT  : T2 hlt
//    others    : NOP
//  - Early end: at the last step of an instruction, step goes to 0 on the next
//    edge, so there are no dead cycles. Otherwise step increments. Step never
//    exceeds NSTEP-1; reaching NSTEP-1 always wraps to 0.
//  - Jump not taken (JC/JZ with flag=0): 3-cycle instruction. IR is still output
//    on the bus (io_=0) but nothing loads it.
//  - Flags are sampled combinationally at T2 and reflect the last fi_ write.
//    ADD/SUB T4 writes the flags on that edge, so a JC/JZ that follows sees the
//    new value.
//  - HLT: on the edge ending T2 with hlt=1, halted<=1 and step<=0. While halted:
//    hlt=1, all other lines idle, step frozen. Only rst leaves the halted state.
//  - Reset mid-instruction aborts it. After rst drops, the next cycle is T0 fetch.
// STRUCTURE
//  - Package kwan_cpu_pkg:
//    - opcode_e enum (values above);
//    - step_t;
//    - ctrl_t packed struct of all control lines;
//    - CTRL_IDLE constant.
//  - Sub-module sap_microcode_rom: purely combinational; (op, step, cf, zf) ->
//    {ctrl_t, last}. The sequencer holds the step counter and halt FSM and
//    applies reset/halt overrides.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> step=0, idle word during reset;
//     T0: co_=0,mi_=0; T1: ro_=0,ii_=0,ce=1.
//  2. ir_op=0010 (ADD) -> T2 io_,mi_; T3 ro_,bi_; T4 eo_=0,ai_=0,fi_=0,su=0;
//     next cycle step=0.
//  3. ir_op=0011 (SUB) -> su=1 in T3/T4 only; fi_=0 only at T4; step sequence
//     0,1,2,3,4,0.
//  4. JC with cf=0 -> j_=1 at T2, step 0,1,2,0; with cf=1 -> j_=0 at T2.
//     Repeat for JZ/zf.
//  5. HLT -> hlt=1 at T2, then halted=1 and step stays 0 for 10+ cycles with cf/zf
//     toggling; rst=1 for 1 cycle -> halted=0, fetch resumes.
//  6. rst asserted at T3 of LDA -> idle word in that cycle, step=0 after;
//     undefined op 1010 -> behaves as NOP (3 cycles, no control lines at T2).

Source files
------------

// File: rtl/kwan_cpu_pkg.sv
// Shared types and constants for the SAP-style 8-bit CPU control path.
// Contents:
//   OPW, NSTEP, STEPW - opcode width, micro-steps per instruction, step width
//   opcode_e          - instruction opcodes
//   step_t            - micro-step counter type (T0..T4)
//   seq_state_e       - run/halt states of the sequencer
//   ctrl_t            - packed control word (active-low lines end in '_')
//   CTRL_IDLE         - control word with every line deasserted
package kwan_cpu_pkg;

  localparam int OPW   = 4;
  localparam int NSTEP = 5;
  localparam int STEPW = $clog2(NSTEP);

  typedef logic [STEPW-1:0] step_t;

  localparam step_t STEP_MAX = step_t'(NSTEP - 1);

  typedef enum logic [OPW-1:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic hlt;
    logic mi_;
    logic ri_;
    logic ro_;
    logic io_;
    logic ii_;
    logic ai_;
    logic ao_;
    logic eo_;
    logic bi_;
    logic oi_;
    logic co_;
    logic j_;
    logic fi_;
    logic su;
    logic ce;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    hlt: 1'b0, mi_: 1'b1, ri_: 1'b1, ro_: 1'b1, io_: 1'b1, ii_: 1'b1,
    ai_: 1'b1, ao_: 1'b1, eo_: 1'b1, bi_: 1'b1, oi_: 1'b1, co_: 1'b1,
    j_: 1'b1, fi_: 1'b1, su: 1'b0, ce: 1'b0
  };

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode ROM: (opcode, micro-step, flags) -> control word.
// Ports:
//   i_op    in  OPW  opcode from instruction register
//   i_step  in  step current micro-step
//   i_cf    in  1    carry flag (used by JC)
//   i_zf    in  1    zero flag (used by JZ)
//   o_ctrl  out      control word for this step
//   o_last  out 1    this step ends the instruction
module sap_microcode_rom
  import kwan_cpu_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  step_t          i_step,
  input  logic           i_cf,
  input  logic           i_zf,
  output ctrl_t          o_ctrl,
  output logic           o_last
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer latches.
  always_comb begin
    o_ctrl = CTRL_IDLE;
    o_last = 1'b0;
    case (i_step)
      3'd0: begin
        o_ctrl.co_ = 1'b0;
        o_ctrl.mi_ = 1'b0;
      end
      3'd1: begin
        o_ctrl.ro_ = 1'b0;
        o_ctrl.ii_ = 1'b0;
        o_ctrl.ce  = 1'b1;
      end
      3'd2: begin
        case (i_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl.io_ = 1'b0;
            o_ctrl.mi_ = 1'b0;
          end
          OP_LDI: begin
            o_ctrl.io_ = 1'b0;
            o_ctrl.ai_ = 1'b0;
            o_last     = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.io_ = 1'b0;
            o_ctrl.j_  = 1'b0;
            o_last     = 1'b1;
          end
          // Conditional jumps always drive IR onto the bus; only the PC load
          // depends on the flag.
          OP_JC: begin
            o_ctrl.io_ = 1'b0;
            o_ctrl.j_  = ~i_cf;
            o_last     = 1'b1;
          end
          OP_JZ: begin
            o_ctrl.io_ = 1'b0;
            o_ctrl.j_  = ~i_zf;
            o_last     = 1'b1;
          end
          OP_OUT: begin
            o_ctrl.ao_ = 1'b0;
            o_ctrl.oi_ = 1'b0;
            o_last     = 1'b1;
          end
          OP_HLT: begin
            o_ctrl.hlt = 1'b1;
            o_last     = 1'b1;
          end
          default: o_last = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      3'd3: begin
        case (i_op)
          OP_LDA: begin
            o_ctrl.ro_ = 1'b0;
            o_ctrl.ai_ = 1'b0;
            o_last     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl.ro_ = 1'b0;
            o_ctrl.bi_ = 1'b0;
            o_ctrl.su  = (i_op == OP_SUB);
          end
          OP_STA: begin
            o_ctrl.ao_ = 1'b0;
            o_ctrl.ri_ = 1'b0;
            o_last     = 1'b1;
          end
          default: o_last = 1'b1;
        endcase
      end
      3'd4: begin
        if (i_op == OP_ADD || i_op == OP_SUB) begin
          o_ctrl.eo_ = 1'b0;
          o_ctrl.ai_ = 1'b0;
          o_ctrl.fi_ = 1'b0;
          o_ctrl.su  = (i_op == OP_SUB);
        end
        o_last = 1'b1;
      end
      default: o_last = 1'b1;
    endcase
    // The final step always wraps, whatever the opcode.
    if (i_step >= STEP_MAX) o_last = 1'b1;
  end

endmodule

// File: rtl/sap_control_seq.sv
// Control sequencer: micro-step counter plus run/halt FSM around the
// microcode ROM. The control word is combinational from the current step,
// opcode, flags and halt state; reset and halt override the ROM output.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ir_op [OPW]         opcode field of the instruction register
//   cf, zf              registered ALU flags
//   hlt, su, ce         active-high control lines
//   mi_ .. fi_          active-low control lines
//   step [3]            current micro-step (debug)
//   halted              halt state reached
module sap_control_seq
  import kwan_cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] ir_op,
  input  logic           cf,
  input  logic           zf,
  output logic           hlt,
  output logic           mi_,
  output logic           ri_,
  output logic           ro_,
  output logic           io_,
  output logic           ii_,
  output logic           ai_,
  output logic           ao_,
  output logic           eo_,
  output logic           bi_,
  output logic           oi_,
  output logic           co_,
  output logic           j_,
  output logic           fi_,
  output logic           su,
  output logic           ce,
  output logic [2:0]     step,
  output logic           halted
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  step_t      r_step;
  step_t      w_step_nxt;
  ctrl_t      w_rom_ctrl;
  logic       w_rom_last;
  ctrl_t      w_ctrl;

  sap_microcode_rom u_rom (
    .i_op   (ir_op),
    .i_step (r_step),
    .i_cf   (cf),
    .i_zf   (zf),
    .o_ctrl (w_rom_ctrl),
    .o_last (w_rom_last)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_ctrl      = CTRL_IDLE;
    case (r_state)
      ST_RUN: begin
        w_ctrl = w_rom_ctrl;
        if (w_rom_ctrl.hlt) begin
          w_state_nxt = ST_HALT;
          w_step_nxt  = '0;
        end else if (w_rom_last) begin
          w_step_nxt = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      ST_HALT: w_ctrl.hlt = 1'b1;  // step frozen, only rst leaves
      default: w_state_nxt = ST_RUN;
    endcase
    // Reset forces the idle word in the same cycle it is asserted.
    if (rst) w_ctrl = CTRL_IDLE;
  end

  assign hlt    = w_ctrl.hlt;
  assign mi_    = w_ctrl.mi_;
  assign ri_    = w_ctrl.ri_;
  assign ro_    = w_ctrl.ro_;
  assign io_    = w_ctrl.io_;
  assign ii_    = w_ctrl.ii_;
  assign ai_    = w_ctrl.ai_;
  assign ao_    = w_ctrl.ao_;
  assign eo_    = w_ctrl.eo_;
  assign bi_    = w_ctrl.bi_;
  assign oi_    = w_ctrl.oi_;
  assign co_    = w_ctrl.co_;
  assign j_     = w_ctrl.j_;
  assign fi_    = w_ctrl.fi_;
  assign su     = w_ctrl.su;
  assign ce     = w_ctrl.ce;
  assign step   = r_step;
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_sap_control_seq.sv
// Directed bench for sap_control_seq: hand-computed control words per step.
module tb_sap_control_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ir_op;
  logic       cf;
  logic       zf;
  logic       hlt, mi_, ri_, ro_, io_, ii_, ai_, ao_, eo_, bi_, oi_, co_, j_, fi_, su, ce;
  logic [2:0] step;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;

  sap_control_seq dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .cf(cf), .zf(zf),
    .hlt(hlt), .mi_(mi_), .ri_(ri_), .ro_(ro_), .io_(io_), .ii_(ii_),
    .ai_(ai_), .ao_(ao_), .eo_(eo_), .bi_(bi_), .oi_(oi_), .co_(co_),
    .j_(j_), .fi_(fi_), .su(su), .ce(ce), .step(step), .halted(halted)
  );

  always #5 clk = ~clk;

  // Observed word: hlt, 13 active-low lines, su, ce.
  logic [15:0] w_obs;
  assign w_obs = {hlt, mi_, ri_, ro_, io_, ii_, ai_, ao_, eo_, bi_, oi_, co_, j_, fi_, su, ce};

  localparam logic [15:0] M_HLT = 16'h8000, M_MI = 16'h4000, M_RI = 16'h2000,
                          M_RO  = 16'h1000, M_IO = 16'h0800, M_II = 16'h0400,
                          M_AI  = 16'h0200, M_AO = 16'h0100, M_EO = 16'h0080,
                          M_BI  = 16'h0040, M_OI = 16'h0020, M_CO = 16'h0010,
                          M_J   = 16'h0008, M_FI = 16'h0004, M_SU = 16'h0002,
                          M_CE  = 16'h0001;
  localparam logic [15:0] IDLE = 16'h7FFC;

  // Idle word with the given active-low lines pulled low and active-high set.
  function automatic logic [15:0] w(input logic [15:0] lo, input logic [15:0] hi);
    return (IDLE & ~lo) | hi;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check step and control word for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] s, input logic [15:0] exp);
    #1;
    check({tag, ".step"}, {13'd0, step}, {13'd0, s});
    check({tag, ".word"}, w_obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    ir_op = op;
    cyc({tag, ".T0"}, 3'd0, w(M_CO | M_MI, 16'h0));
    cyc({tag, ".T1"}, 3'd1, w(M_RO | M_II, M_CE));
  endtask

  initial begin
    rst = 1'b1; ir_op = 4'b0000; cf = 1'b0; zf = 1'b0;
    #1;
    check("rst.idle0", w_obs, IDLE);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst.idle", w_obs, IDLE);
    end
    check("rst.step", {13'd0, step}, 16'd0);
    check("rst.halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;

    // ADD
    fetch("add", 4'b0010);
    cyc("add.T2", 3'd2, w(M_IO | M_MI, 16'h0));
    cyc("add.T3", 3'd3, w(M_RO | M_BI, 16'h0));
    cyc("add.T4", 3'd4, w(M_EO | M_AI | M_FI, 16'h0));

    // SUB (also confirms wrap back to T0 after ADD)
    fetch("sub", 4'b0011);
    cyc("sub.T2", 3'd2, w(M_IO | M_MI, 16'h0));
    cyc("sub.T3", 3'd3, w(M_RO | M_BI, M_SU));
    cyc("sub.T4", 3'd4, w(M_EO | M_AI | M_FI, M_SU));

    // JC not taken / taken
    cf = 1'b0;
    fetch("jc0", 4'b0111);
    cyc("jc0.T2", 3'd2, w(M_IO, 16'h0));
    cf = 1'b1;
    fetch("jc1", 4'b0111);
    cyc("jc1.T2", 3'd2, w(M_IO | M_J, 16'h0));
    cf = 1'b0;

    // JZ not taken / taken (cf set to show it is ignored)
    zf = 1'b0; cf = 1'b1;
    fetch("jz0", 4'b1000);
    cyc("jz0.T2", 3'd2, w(M_IO, 16'h0));
    zf = 1'b1; cf = 1'b0;
    fetch("jz1", 4'b1000);
    cyc("jz1.T2", 3'd2, w(M_IO | M_J, 16'h0));
    zf = 1'b0;

    // Remaining opcodes
    fetch("sta", 4'b0100);
    cyc("sta.T2", 3'd2, w(M_IO | M_MI, 16'h0));
    cyc("sta.T3", 3'd3, w(M_AO | M_RI, 16'h0));
    fetch("ldi", 4'b0101);
    cyc("ldi.T2", 3'd2, w(M_IO | M_AI, 16'h0));
    fetch("jmp", 4'b0110);
    cyc("jmp.T2", 3'd2, w(M_IO | M_J, 16'h0));
    fetch("out", 4'b1110);
    cyc("out.T2", 3'd2, w(M_AO | M_OI, 16'h0));
    fetch("nop", 4'b0000);
    cyc("nop.T2", 3'd2, IDLE);

    // LDA aborted by reset at T3
    fetch("lda", 4'b0001);
    cyc("lda.T2", 3'd2, w(M_IO | M_MI, 16'h0));
    rst = 1'b1;
    #1;
    check("lda.T3rst.word", w_obs, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("lda.after.step", {13'd0, step}, 16'd0);

    // Undefined opcode behaves as NOP
    fetch("u1010", 4'b1010);
    cyc("u1010.T2", 3'd2, IDLE);

    // HLT
    fetch("hlt", 4'b1111);
    cyc("hlt.T2", 3'd2, w(16'h0, M_HLT));
    for (int i = 0; i < 12; i++) begin
      cf = i[0];
      zf = i[1];
      #1;
      check("halt.flag", {15'd0, halted}, 16'd1);
      cyc("halt.hold", 3'd0, w(16'h0, M_HLT));
    end
    cf = 1'b0; zf = 1'b0;
    rst = 1'b1;
    #1;
    check("halt.rst.word", w_obs, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("halt.rst.halted", {15'd0, halted}, 16'd0);
    fetch("resume", 4'b0001);
    cyc("resume.T2", 3'd2, w(M_IO | M_MI, 16'h0));
    cyc("resume.T3", 3'd3, w(M_RO | M_AI, 16'h0));
    cyc("resume.wrap", 3'd0, w(M_CO | M_MI, 16'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
